// File: rtl/racod_pkg.sv
// racod_pkg -- shared constants and types for the RACOD configuration sequencer.
// Holds the packed-configuration geometry, the field order of a pose and
// the sequencer state encoding.
package racod_pkg;

  // Number of configuration words that make up one pose.
  localparam int N_FIELDS = 6;

  // Default word width and the matching packed configuration width.
  localparam int WORD_W_DEF = 32;
  localparam int CFG_W      = N_FIELDS * WORD_W_DEF;

  // Field slots inside cfg_data, in arrival order.
  localparam int F_OX  = 0;
  localparam int F_OY  = 1;
  localparam int F_LEN = 2;
  localparam int F_WID = 3;
  localparam int F_SIN = 4;
  localparam int F_COS = 5;

  // Sequencer states: gather words, strobe config, observe, hand back result.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    REPORT  = 2'd3
  } seq_state_t;

  // Packed configuration width for an arbitrary word width.
  function automatic int cfg_width(input int word_w);
    return N_FIELDS * word_w;
  endfunction

endpackage

// File: rtl/racod_cfg_pack.sv
// racod_cfg_pack -- assembles six pose words into the packed configuration.
// The k-th accepted word lands in slot k (origin_x first, cos last). The
// slots are only overwritten by new words, so the packed value stays stable
// from the config strobe until the first word of the next pose arrives.
module racod_cfg_pack
  import racod_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         accept,
  input  logic [WORD_W-1:0]            in_word,
  output logic [N_FIELDS*WORD_W-1:0]   cfg_data,
  output logic                         last_word
);

  logic [2:0] word_cnt_reg;

  // The sixth accept completes the pose; the sequencer leaves COLLECT on it.
  assign last_word = accept && (word_cnt_reg == 3'(F_COS));

  // Word counter: advances per accept and returns to 0 as the pose completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt_reg <= 3'd0;
    end else if (accept) begin
      if (last_word) begin
        word_cnt_reg <= 3'd0;
      end else begin
        word_cnt_reg <= word_cnt_reg + 3'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_FIELDS; gi++) begin : g_field
      logic [WORD_W-1:0] field_reg;

      // Slot register: captures the word whose arrival index matches this slot.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          field_reg <= '0;
        end else if (accept && (word_cnt_reg == 3'(gi))) begin
          field_reg <= in_word;
        end
      end

      assign cfg_data[WORD_W*gi +: WORD_W] = field_reg;
    end
  endgenerate

endmodule

// File: rtl/racod_cfg_seq.sv
// racod_cfg_seq -- pose configuration sequencer for the RACOD collision detector.
// Collects six pose words, strobes the packed configuration for one cycle,
// observes the detector's collision flag for WAIT_CYCLES cycles and then
// presents an indexed result on a valid/ready handshake.
// Build option: define RACOD_SEQ_STICKY_COLLISION_EN to report the OR of the
// collision flag over the whole observation window; otherwise only the value
// on the last window cycle is reported.
module racod_cfg_seq
  import racod_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int WAIT_CYCLES = 12,
  parameter int IDX_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_W-1:0]           in_word,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N_FIELDS*WORD_W-1:0]  cfg_data,
  output logic                        cfg_valid,
  input  logic                        collision,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        res_collision,
  output logic [IDX_W-1:0]            res_index,
  output logic                        busy
);

  // Window length as loaded into the 8-bit down-counter.
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);

  seq_state_t        state_reg;
  logic [7:0]        wait_cnt_reg;
  logic              in_ready_reg;
  logic              busy_reg;
  logic              cfg_valid_reg;
  logic              res_valid_reg;
  logic              res_collision_reg;
  logic [IDX_W-1:0]  res_index_reg;

  logic              accept;
  logic              last_word;
  logic              collision_cap;

  // Words are taken only while collecting; the ready register mirrors COLLECT.
  assign accept = in_valid && in_ready_reg;

  racod_cfg_pack #(
    .WORD_W (WORD_W)
  ) u_pack (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .in_word   (in_word),
    .cfg_data  (cfg_data),
    .last_word (last_word)
  );

`ifdef RACOD_SEQ_STICKY_COLLISION_EN
  logic sticky_reg;

  // Accumulate any collision seen in the window; cleared as WAIT is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_reg <= 1'b0;
    end else if (state_reg == ISSUE) begin
      sticky_reg <= 1'b0;
    end else if (state_reg == WAIT) begin
      sticky_reg <= sticky_reg | collision;
    end
  end

  assign collision_cap = sticky_reg | collision;
`else
  assign collision_cap = collision;
`endif

  // Sequencer FSM with its window counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= COLLECT;
      wait_cnt_reg      <= 8'd0;
      in_ready_reg      <= 1'b1;
      busy_reg          <= 1'b0;
      cfg_valid_reg     <= 1'b0;
      res_valid_reg     <= 1'b0;
      res_collision_reg <= 1'b0;
      res_index_reg     <= '0;
    end else begin
      cfg_valid_reg <= 1'b0;
      case (state_reg)
        COLLECT: begin
          if (last_word) begin
            state_reg     <= ISSUE;
            cfg_valid_reg <= 1'b1;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b1;
          end
        end
        ISSUE: begin
          state_reg    <= WAIT;
          wait_cnt_reg <= WAIT_LOAD;
        end
        WAIT: begin
          if (wait_cnt_reg == 8'd1) begin
            // Last window cycle: latch the verdict and offer the result.
            state_reg         <= REPORT;
            wait_cnt_reg      <= 8'd0;
            res_valid_reg     <= 1'b1;
            res_collision_reg <= collision_cap;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 8'd1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            state_reg     <= COLLECT;
            res_valid_reg <= 1'b0;
            res_index_reg <= res_index_reg + IDX_W'(1);
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg <= COLLECT;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_reg;
  assign busy          = busy_reg;
  assign cfg_valid     = cfg_valid_reg;
  assign res_valid     = res_valid_reg;
  assign res_collision = res_collision_reg;
  assign res_index     = res_index_reg;

endmodule

// File: tb/tb_racod_cfg_seq.sv
// tb_racod_cfg_seq -- scoreboard bench for racod_cfg_seq.
// Stimulus pushes expected configs/results into queues; a negedge monitor
// pops and compares whenever the DUT strobes cfg_valid or raises res_valid.
module tb_racod_cfg_seq;
  import racod_pkg::*;

  localparam int WORD_W      = 32;
  localparam int WAIT_CYCLES = 12;
  localparam int IDX_W       = 2;
  localparam int CW          = 6 * WORD_W;
`ifdef RACOD_SEQ_STICKY_COLLISION_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef logic [WORD_W-1:0] pose_t [6];
  typedef struct packed {
    logic             coll;
    logic [IDX_W-1:0] idx;
  } res_t;

  logic              clk;
  logic              rst;
  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     cfg_data;
  logic              cfg_valid;
  logic              collision;
  logic              res_valid;
  logic              res_ready;
  logic              res_collision;
  logic [IDX_W-1:0]  res_index;
  logic              busy;

  racod_cfg_seq #(
    .WORD_W      (WORD_W),
    .WAIT_CYCLES (WAIT_CYCLES),
    .IDX_W       (IDX_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_word       (in_word),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .collision     (collision),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_collision (res_collision),
    .res_index     (res_index),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  res_t          res_q[$];
  logic [CW-1:0] cfg_q[$];
  logic [IDX_W-1:0] exp_idx = '0;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: tracks accepts, checks cfg strobe and result against the queues.
  int            acc_cnt = 0;
  int            last6   = -1000;
  logic          prev_rv = 1'b0;
  res_t          cur_res;
  logic [CW-1:0] cur_cfg = '0;

  always @(negedge clk) begin
    if (!rst) begin
      acc_cnt = 0;
      prev_rv = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        if (acc_cnt == 5) begin
          acc_cnt = 0;
          last6   = cyc;
        end else begin
          acc_cnt++;
        end
      end
      if (cfg_valid) begin
        chk("cfg_latency", cyc - last6, 1);
        chk("cfg_expected", cfg_q.size() != 0, 1);
        if (cfg_q.size() != 0) begin
          cur_cfg = cfg_q.pop_front();
          chk("cfg_data", cfg_data, cur_cfg);
          $display("cfg  cycle=%0d data=%0h", cyc, cfg_data);
        end
      end
      if (res_valid && !prev_rv) begin
        chk("res_latency", cyc - last6, WAIT_CYCLES + 2);
        chk("res_expected", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          cur_res = res_q.pop_front();
          chk("res_index", res_index, cur_res.idx);
          chk("res_collision", res_collision, cur_res.coll);
          $display("res  cycle=%0d index=%0d collision=%0b", cyc, res_index, res_collision);
        end
      end else if (res_valid) begin
        chk("res_index_hold", res_index, cur_res.idx);
        chk("res_collision_hold", res_collision, cur_res.coll);
      end
      if (res_valid) begin
        chk("busy_in_report", busy, 1);
        chk("in_ready_in_report", in_ready, 0);
        chk("cfg_data_hold", cfg_data, cur_cfg);
      end
      prev_rv = res_valid;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_cfg_data"}, cfg_data, 0);
    chk({tag, "_cfg_valid"}, cfg_valid, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_collision"}, res_collision, 0);
    chk({tag, "_res_index"}, res_index, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  // Asynchronous reset mid-cycle, checked immediately, then released.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check_reset_values(tag);
    cfg_q.delete();
    res_q.delete();
    exp_idx   = '0;
    in_valid  = 1'b0;
    collision = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_in_ready_after_release"}, in_ready, 1);
  endtask

  task automatic send_words(input pose_t w, input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_word  = w[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (gapped) begin
        in_word = 32'hDEAD_0000 + i;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_res(input string tag);
    int t = 0;
    while (!res_valid && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, "_res_timeout"}, res_valid, 1);
  endtask

  task automatic run_pose(input string tag, input pose_t w, input int coll_k,
                          input bit exp_coll, input bit gapped, input int hold);
    cfg_q.push_back({w[5], w[4], w[3], w[2], w[1], w[0]});
    res_q.push_back(res_t'{coll: exp_coll, idx: exp_idx});
    exp_idx   = exp_idx + 1'b1;
    res_ready = (hold == 0);
    send_words(w, 6, gapped);
    if (gapped) begin
      // Keep offering junk while busy; none of it may be consumed.
      for (int j = 0; j < 6; j++) begin
        in_valid = (j % 2 == 0);
        in_word  = 32'hBAD0_0000 + j;
        @(posedge clk);
        #1;
        chk({tag, "_no_accept_busy"}, in_ready, 0);
      end
      in_valid = 1'b0;
    end
    if (coll_k > 0) begin
      repeat (coll_k) @(posedge clk);
      #1;
      collision = 1'b1;
      @(posedge clk);
      #1;
      collision = 1'b0;
    end
    wait_res(tag);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
        chk({tag, "_bp_valid"}, res_valid, 1);
        chk({tag, "_bp_in_ready"}, in_ready, 0);
        chk({tag, "_bp_busy"}, busy, 1);
      end
      res_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, "_release_valid"}, res_valid, 0);
    chk({tag, "_release_in_ready"}, in_ready, 1);
    chk({tag, "_release_busy"}, busy, 0);
  endtask

  initial begin
    pose_t p;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    collision = 1'b0;
    res_ready = 1'b1;
    #12;
    check_reset_values("init");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("init_in_ready_after_release", in_ready, 1);

    p = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    run_pose("basic", p, 0, 1'b0, 1'b0, 0);

    p = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    run_pose("coll_mid", p, 3, STICKY, 1'b0, 0);

    p = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6};
    run_pose("coll_last", p, WAIT_CYCLES, 1'b1, 1'b0, 0);

    p = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004, 32'h5000_0005, 32'h6000_0006};
    run_pose("backpressure", p, 0, 1'b0, 1'b0, 20);

    p = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
    run_pose("gapped", p, 0, 1'b0, 1'b1, 0);

    // Reset after three words of a pose: partial words discarded.
    p = '{32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'hE5, 32'hE6};
    send_words(p, 3, 1'b0);
    do_reset("rst_mid_pose");
    p = '{32'h7, 32'h8, 32'h9, 32'hA, 32'hB, 32'hC};
    run_pose("after_rst_pose", p, 0, 1'b0, 1'b0, 0);

    // Reset in the middle of the observation window: result discarded.
    p = '{32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5, 32'hF6};
    cfg_q.push_back({p[5], p[4], p[3], p[2], p[1], p[0]});
    send_words(p, 6, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    do_reset("rst_mid_wait");
    p = '{32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26};
    run_pose("after_rst_wait", p, 0, 1'b0, 1'b0, 0);

    repeat (20) @(posedge clk);
    #1;
    chk("sb_res_drained", res_q.size(), 0);
    chk("sb_cfg_drained", cfg_q.size(), 0);
    chk("idle_res_valid", res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
